// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, FSM encoding and wait limits for the async SRAM front-end
package sram_pkg;

    localparam int ADDR_W_DEF      = 18;
    localparam int DATA_W_DEF      = 16;
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int CNT_W           = $clog2(MAX_WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word request sequencer driving a 256Kx16 asynchronous SRAM
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cs_n,
    output logic              sram_rd_n,
    output logic              sram_wr_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    sram_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    if (req_we) begin
                        wdata_d = req_wdata;
                    end
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                rd_n_d  = we_q;
                wr_n_d  = ~we_q;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                // Read data is sampled on the same edge the strobe is released.
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rsp_rdata_d = sram_rdata;
                    end
                    rsp_valid_d = 1'b1;
                    rd_n_d      = 1'b1;
                    wr_n_d      = 1'b1;
                    cs_n_d      = 1'b1;
                    state_d     = RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE) & ~rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign sram_cs_n  = cs_n_q;
    assign sram_rd_n  = rd_n_q;
    assign sram_wr_n  = wr_n_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - bench for sram_ctrl with WAIT_CYCLES=1 and WAIT_CYCLES=3 instances
module tb_sram_ctrl;

    localparam int  AW     = 18;
    localparam int  DW     = 16;
    localparam time PERIOD = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(PERIOD / 2) clk = ~clk;

    logic [1:0]         req_valid, req_ready, req_we, rsp_valid, cs_n, rd_n, wr_n;
    logic [1:0][AW-1:0] req_addr, sram_addr;
    logic [1:0][DW-1:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;

    logic [DW-1:0] sram_mem [2][262144];
    logic          preload_en = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [DW-1:0] preload_data = '0;

    int rd_low[2], wr_low[2], overlap[2], instab[2], rsp_cnt[2];
    logic [AW-1:0] prev_addr[2];
    logic [DW-1:0] prev_wdata[2];
    logic          act_prev[2];

    logic [DW-1:0] ref_mem [logic [AW:0]];
    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .sram_cs_n  (cs_n[g]),
            .sram_rd_n  (rd_n[g]),
            .sram_wr_n  (wr_n[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_rdata (sram_rdata[g])
        );
    end

    // SRAM array model: writes land while the write strobe is low, reads are combinational.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++)
            if (!cs_n[g] && !wr_n[g]) sram_mem[g][sram_addr[g]] <= sram_wdata[g];
        if (preload_en) sram_mem[1][preload_addr] <= preload_data;
    end

    always_comb begin
        sram_rdata = '0;
        for (int g = 0; g < 2; g++)
            sram_rdata[g] = (!cs_n[g] && !rd_n[g]) ? sram_mem[g][sram_addr[g]] : 16'hDEAD;
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            rd_low[g] = 0; wr_low[g] = 0; overlap[g] = 0; instab[g] = 0; rsp_cnt[g] = 0;
            prev_addr[g] = '0; prev_wdata[g] = '0; act_prev[g] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic act;
            act = !cs_n[g] || !rd_n[g] || !wr_n[g];
            if (!rd_n[g]) rd_low[g]++;
            if (!wr_n[g]) wr_low[g]++;
            if (!rd_n[g] && !wr_n[g]) overlap[g]++;
            if (rsp_valid[g]) rsp_cnt[g]++;
            if (act && act_prev[g] && (sram_addr[g] != prev_addr[g] || sram_wdata[g] != prev_wdata[g]))
                instab[g]++;
            act_prev[g]   = act;
            prev_addr[g]  = sram_addr[g];
            prev_wdata[g] = sram_wdata[g];
        end
    end

    // Issues one request on instance d; called and returns on a negedge.
    task automatic txn(input int d, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit keep, input bit scramble,
                       output logic [DW-1:0] rdata, output int lat, output int stb,
                       output time t_acc);
        int n, s0;
        lat = -1; stb = -1; rdata = '0; t_acc = 0;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        n = 0;
        while (!req_ready[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        s0 = rd_low[d] + wr_low[d];
        if (we) ref_mem[{d[0], addr}] = wdata;
        lat = 0;
        @(negedge clk);
        if (!keep && !scramble) req_valid[d] = 1'b0;
        while (lat < 40) begin
            if (scramble) begin
                req_addr[d]  = AW'($urandom);
                req_wdata[d] = DW'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid[d]) break;
        end
        if (!keep) req_valid[d] = 1'b0;
        rdata = rsp_rdata[d];
        stb = rd_low[d] + wr_low[d] - s0;
    endtask

    task automatic test_reset();
        req_valid = 2'b11; req_we = 2'b11;
        req_addr[0] = 18'h12345; req_addr[1] = 18'h00777;
        req_wdata[0] = 16'h1111; req_wdata[1] = 16'h2222;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                n_tests++;
                if ({cs_n[g], rd_n[g], wr_n[g], req_ready[g], rsp_valid[g]} !== 5'b11100) begin
                    n_fail++;
                    $display("FAIL reset_outputs[%0d] cyc %0d: got cs/rd/wr/ready/rsp=%b required 11100",
                             g, i, {cs_n[g], rd_n[g], wr_n[g], req_ready[g], rsp_valid[g]});
                end
            end
        end
        n_tests++;
        if (sram_addr[0] !== '0 || sram_wdata[0] !== '0 || rsp_rdata[0] !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got addr=%h wdata=%h rdata=%h required 0/0/0",
                     sram_addr[0], sram_wdata[0], rsp_rdata[0]);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DW-1:0] rd;
        int lat, stb;
        time t;
        txn(0, 1'b1, 18'h3FFFF, 16'hBEEF, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (lat !== 2 || stb !== 1) begin
            n_fail++;
            $display("FAIL basic_write_timing: got lat=%0d strobe=%0d required 2/1", lat, stb);
        end
        txn(0, 1'b0, 18'h3FFFF, 16'h0000, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (rd !== ref_mem[{1'b0, 18'h3FFFF}] || lat !== 2 || stb !== 1) begin
            n_fail++;
            $display("FAIL basic_read: got data=%h lat=%0d strobe=%0d required %h/2/1",
                     rd, lat, stb, ref_mem[{1'b0, 18'h3FFFF}]);
        end
        txn(0, 1'b1, 18'h00042, 16'h0F0F, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rdata_hold_after_write: got %h required beef", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd;
        int lat, stb;
        time t0, t1;
        logic [AW-1:0] addrs [4] = '{18'h00000, 18'h00001, 18'h00000, 18'h00001};
        logic [DW-1:0] datas [4] = '{16'h1234, 16'h5678, 16'h0000, 16'h0000};
        logic          wes   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] exp_rd;
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            txn(0, wes[i], addrs[i], datas[i], i < 3, 1'b0, rd, lat, stb, t1);
            if (i > 0) begin
                n_tests++;
                if (t1 - t0 !== 4 * PERIOD) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0t required %0t", i, t1 - t0, 4 * PERIOD);
                end
            end
            if (!wes[i]) begin
                exp_rd = ref_mem[{1'b0, addrs[i]}];
                n_tests++;
                if (rd !== exp_rd) begin
                    n_fail++;
                    $display("FAIL b2b_read[%0d]: got %h required %h", i, rd, exp_rd);
                end
            end
            t0 = t1;
        end
    endtask

    task automatic test_wait3();
        logic [DW-1:0] rd;
        int lat, stb;
        time t;
        preload_en = 1'b1; preload_addr = 18'h00010; preload_data = 16'hA5A5;
        @(negedge clk);
        preload_en = 1'b0;
        ref_mem[{1'b1, 18'h00010}] = 16'hA5A5;
        txn(1, 1'b0, 18'h00010, 16'h0000, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (rd !== 16'hA5A5 || lat !== 4 || stb !== 3) begin
            n_fail++;
            $display("FAIL wait3_read: got data=%h lat=%0d strobe=%0d required a5a5/4/3", rd, lat, stb);
        end
        txn(1, 1'b1, 18'h20000, 16'hC0DE, 1'b0, 1'b0, rd, lat, stb, t);
        txn(1, 1'b0, 18'h20000, 16'h0000, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (rd !== ref_mem[{1'b1, 18'h20000}] || lat !== 4 || stb !== 3) begin
            n_fail++;
            $display("FAIL wait3_write_read: got data=%h lat=%0d strobe=%0d required %h/4/3",
                     rd, lat, stb, ref_mem[{1'b1, 18'h20000}]);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] rd;
        int lat, stb, n, r0;
        time t;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 18'h00001;
        n = 0;
        while (!req_ready[0] && n < 40) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (rd_n[0] && n < 10) begin @(negedge clk); n++; end
        n_tests++;
        if (rd_n[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_access_reached: got rd_n=%b required 0", rd_n[0]);
        end
        r0 = rsp_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({cs_n[0], rd_n[0], wr_n[0], rsp_valid[0]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL midrst_outputs: got cs/rd/wr/rsp=%b required 1110",
                     {cs_n[0], rd_n[0], wr_n[0], rsp_valid[0]});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (rsp_cnt[0] !== r0) begin
            n_fail++;
            $display("FAIL midrst_no_response: got %0d responses required 0", rsp_cnt[0] - r0);
        end
        txn(0, 1'b0, 18'h00001, 16'h0000, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (rd !== ref_mem[{1'b0, 18'h00001}] || lat !== 2) begin
            n_fail++;
            $display("FAIL midrst_recovery_read: got data=%h lat=%0d required %h/2",
                     rd, lat, ref_mem[{1'b0, 18'h00001}]);
        end
    endtask

    task automatic test_busy_hold();
        logic [DW-1:0] rd;
        int lat, stb;
        time t;
        txn(0, 1'b1, 18'h00ABC, 16'h7E57, 1'b0, 1'b1, rd, lat, stb, t);
        n_tests++;
        if (sram_mem[0][18'h00ABC] !== 16'h7E57 || lat !== 2) begin
            n_fail++;
            $display("FAIL busy_hold_write: got mem=%h lat=%0d required 7e57/2",
                     sram_mem[0][18'h00ABC], lat);
        end
        txn(0, 1'b0, 18'h00ABC, 16'h0000, 1'b0, 1'b0, rd, lat, stb, t);
        n_tests++;
        if (rd !== ref_mem[{1'b0, 18'h00ABC}]) begin
            n_fail++;
            $display("FAIL busy_hold_read: got %h required %h", rd, ref_mem[{1'b0, 18'h00ABC}]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [6];
        logic [DW-1:0] rd, exp_rd;
        logic we;
        int lat, stb, k;
        time t;
        for (int i = 0; i < 6; i++) begin
            pool[i] = (i == 0) ? 18'h3FFFF : AW'($urandom);
            txn(0, 1'b1, pool[i], DW'($urandom), 1'b0, 1'b0, rd, lat, stb, t);
        end
        for (int i = 0; i < 16; i++) begin
            k  = int'($urandom_range(0, 5));
            we = 1'($urandom);
            exp_rd = ref_mem[{1'b0, pool[k]}];
            txn(0, we, pool[k], DW'($urandom), 1'b0, 1'b0, rd, lat, stb, t);
            n_tests++;
            if (lat !== 2 || stb !== 1 || (!we && rd !== exp_rd)) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b addr=%h: got data=%h lat=%0d strobe=%0d required %h/2/1",
                         i, we, pool[k], rd, lat, stb, exp_rd);
            end
        end
    endtask

    task automatic test_protocol();
        for (int g = 0; g < 2; g++) begin
            n_tests++;
            if (overlap[g] !== 0 || instab[g] !== 0) begin
                n_fail++;
                $display("FAIL protocol[%0d]: got overlap=%0d unstable=%0d required 0/0",
                         g, overlap[g], instab[g]);
            end
        end
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_wait3();
        test_mid_reset();
        test_busy_hold();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
